// File: rtl/fpmul_stream.sv
// fpmul_stream: sequential IEEE-754 style multiplier with a single-transfer stream interface.
//
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   in_valid        a, b, rm are valid           in_ready   block can accept an operation
//   a, b            operands (sign | exponent | stored mantissa)
//   rm              rounding mode: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
//   out_valid       out/flags hold a result      out_ready  consumer takes the result
//   out             product
//   flags           {NV, OF, UF, NX}
//   dbg_state       current FSM state encoding
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready is 1 only while idle, so a new operation is never accepted while a result
// is pending. Once out_valid rises, out and flags stay constant until the transfer.
//
// Flow: IDLE -> MUL (one shift-add step per significand bit) -> NORM -> ROUND -> DONE.
// out_valid is a flop loaded while in DONE, so it rises MAN_BIT+4 edges after the accept
// edge. Special operands (NaN, inf, zero) take the same path and are resolved in ROUND.
module fpmul_stream #(
  parameter int LOG_BIT = 5,
  parameter int EXP_BIT = 8,
  parameter int N_BIT   = 1 << LOG_BIT,
  parameter int MAN_BIT = N_BIT - EXP_BIT - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic [1:0]       rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_BIT-1:0] out,
  output logic [3:0]       flags,
  output logic [2:0]       dbg_state
);

  localparam int SIG_W  = MAN_BIT + 1;
  localparam int PROD_W = 2 * MAN_BIT + 2;
  localparam int EW     = EXP_BIT + 2;
  localparam int CNT_W  = $clog2(SIG_W) + 1;
  localparam int LZ_W   = $clog2(PROD_W) + 1;

  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);
  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_BIT - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_BIT) - 1);
  localparam logic [N_BIT-1:0] QNAN = {1'b0, {EXP_BIT{1'b1}}, 1'b1, {(MAN_BIT-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Denormals use hidden bit 0 and effective exponent 1.
  function automatic logic [SIG_W-1:0] eff_sig(input logic [EXP_BIT-1:0] e,
                                               input logic [MAN_BIT-1:0] m);
    return {|e, m};
  endfunction

  function automatic logic signed [EW-1:0] eff_exp(input logic [EXP_BIT-1:0] e);
    if (e == '0) return EXP_ONE;
    return {2'b00, e};
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_BIT-1:0]       a_q, a_d, b_q, b_d;
  logic [1:0]             rm_q, rm_d;
  logic [SIG_W-1:0]       mcand_q, mcand_d;
  logic [PROD_W-1:0]      prod_q, prod_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [N_BIT-1:0]       out_q, out_d;
  logic [3:0]             flags_q, flags_d;
  logic                   out_valid_q, out_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rm_q        <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      exp_q       <= '0;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rm_q        <= rm_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      exp_q       <= exp_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign flags     = flags_q;
  assign dbg_state = state_q;

  // Leading-zero count of the raw product.
  logic [LZ_W-1:0]      lz;
  logic                 lz_found;
  logic signed [EW-1:0] lz_s;
  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = PROD_W - 1; i >= 0; i--) begin
      if (!lz_found && prod_q[i]) begin
        lz       = LZ_W'(PROD_W - 1 - i);
        lz_found = 1'b1;
      end
    end
    lz_s = EW'(lz);
  end

  // Rounding and special-operand resolution, consumed in ROUND.
  // After NORM the leading one sits at the product MSB, so the stored mantissa,
  // guard and sticky fields are at fixed positions.
  logic                 r_sign, r_guard, r_sticky, r_lsb, r_inc, r_use_inf;
  logic [MAN_BIT+1:0]   r_man;
  logic [MAN_BIT-1:0]   r_frac;
  logic signed [EW-1:0] r_exp;
  logic                 a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic [N_BIT-1:0]     res;
  logic [3:0]           res_flags;
  always_comb begin
    r_sign   = a_q[N_BIT-1] ^ b_q[N_BIT-1];
    r_guard  = prod_q[MAN_BIT];
    r_sticky = |prod_q[MAN_BIT-1:0];
    r_lsb    = prod_q[MAN_BIT+1];
    unique case (rm_q)
      2'b00:   r_inc = r_guard & (r_sticky | r_lsb);
      2'b01:   r_inc = 1'b0;
      2'b10:   r_inc = (r_guard | r_sticky) & ~r_sign;
      default: r_inc = (r_guard | r_sticky) & r_sign;
    endcase
    unique case (rm_q)
      2'b00:   r_use_inf = 1'b1;
      2'b01:   r_use_inf = 1'b0;
      2'b10:   r_use_inf = ~r_sign;
      default: r_use_inf = r_sign;
    endcase
    r_man  = {1'b0, prod_q[PROD_W-1:MAN_BIT+1]} + {{(MAN_BIT+1){1'b0}}, r_inc};
    // Carry out of the mantissa: shift back by one and bump the exponent.
    r_exp  = r_man[MAN_BIT+1] ? exp_q + EXP_ONE : exp_q;
    r_frac = r_man[MAN_BIT+1] ? r_man[MAN_BIT:1] : r_man[MAN_BIT-1:0];

    a_nan  = (&a_q[N_BIT-2:MAN_BIT]) & (|a_q[MAN_BIT-1:0]);
    b_nan  = (&b_q[N_BIT-2:MAN_BIT]) & (|b_q[MAN_BIT-1:0]);
    a_snan = a_nan & ~a_q[MAN_BIT-1];
    b_snan = b_nan & ~b_q[MAN_BIT-1];
    a_inf  = (&a_q[N_BIT-2:MAN_BIT]) & ~(|a_q[MAN_BIT-1:0]);
    b_inf  = (&b_q[N_BIT-2:MAN_BIT]) & ~(|b_q[MAN_BIT-1:0]);
    a_zero = ~(|a_q[N_BIT-2:0]);
    b_zero = ~(|b_q[N_BIT-2:0]);

    res       = {r_sign, r_exp[EXP_BIT-1:0], r_frac};
    res_flags = {3'b000, r_guard | r_sticky};
    if (a_nan || b_nan) begin
      res       = QNAN;
      res_flags = {a_snan | b_snan, 3'b000};
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      res       = QNAN;
      res_flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      res       = {r_sign, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
      res_flags = 4'b0000;
    end else if (a_zero || b_zero) begin
      res       = {r_sign, {(N_BIT-1){1'b0}}};
      res_flags = 4'b0000;
    end else if (r_exp >= EXP_MAX) begin
      res       = r_use_inf ? {r_sign, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}}
                            : {r_sign, {(EXP_BIT-1){1'b1}}, 1'b0, {MAN_BIT{1'b1}}};
      res_flags = 4'b0101;
    end else if (r_exp <= EXP_ZERO) begin
      res       = {r_sign, {(N_BIT-1){1'b0}}};
      res_flags = 4'b0011;
    end
  end

  logic [SIG_W:0] mul_sum;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    rm_d        = rm_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    exp_d       = exp_q;
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    mul_sum     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          rm_d    = rm;
          mcand_d = eff_sig(a[N_BIT-2:MAN_BIT], a[MAN_BIT-1:0]);
          prod_d  = {{SIG_W{1'b0}}, eff_sig(b[N_BIT-2:MAN_BIT], b[MAN_BIT-1:0])};
          exp_d   = eff_exp(a[N_BIT-2:MAN_BIT]) + eff_exp(b[N_BIT-2:MAN_BIT]) - BIAS;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        // Multiplier sits in the low half and shifts out as the partial sum shifts in.
        mul_sum = {1'b0, prod_q[PROD_W-1:SIG_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d  = {mul_sum, prod_q[SIG_W-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SIG_W - 1)) begin
          cnt_d   = '0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        // Product >= 2.0 keeps its bits and only bumps the exponent; otherwise shift
        // the leading one up to the MSB, losing (lz-1) from the exponent.
        if (prod_q[PROD_W-1]) begin
          exp_d = exp_q + EXP_ONE;
        end else begin
          prod_d = prod_q << lz;
          exp_d  = exp_q - lz_s + EXP_ONE;
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        out_d   = res;
        flags_d = res_flags;
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpmul_stream.sv
module tb_fpmul_stream;

  localparam int LAT = 27;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [3:0]  flags;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [35:0] exp_q[$];
  int          acc_q[$];

  fpmul_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // driver tasks: called at posedge+1
  task automatic wait_idle();
    int g;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] trm,
                      input logic [31:0] eo, input logic [3:0] ef, input bit keep);
    wait_idle();
    if (!in_ready) return;
    a        = ta;
    b        = tb;
    rm       = trm;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (keep) begin
      exp_q.push_back({ef, eo});
      acc_q.push_back(cyc);
    end
  endtask

  // scoreboard monitor
  initial begin
    bit          prev_v;
    int          n_out;
    int          t;
    logic [35:0] e;
    prev_v = 1'b0;
    n_out  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          if (acc_q.size() == 0) begin
            check("spurious_valid", {31'b0, out_valid}, 32'd0);
          end else begin
            t = acc_q.pop_front();
            check($sformatf("latency%0d", n_out), cyc - t, LAT);
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", out, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("out%0d", n_out), out, e[31:0]);
            check($sformatf("flags%0d", n_out), {28'b0, flags}, {28'b0, e[35:32]});
            n_out++;
          end
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin
    int g;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    rm        = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out, 32'h0);
    check("rst_flags", {28'b0, flags}, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed vectors: a, b, rm, expected out, expected flags {NV,OF,UF,NX}
    send(32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000, 1'b1);
    send(32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 4'b0001, 1'b1);
    send(32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 4'b0001, 1'b1);
    send(32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 4'b0001, 1'b1);
    send(32'hBF800001, 32'h3F800001, 2'b11, 32'hBF800003, 4'b0001, 1'b1);
    send(32'hBF800001, 32'h3F800001, 2'b10, 32'hBF800002, 4'b0001, 1'b1);
    send(32'h7F7FFFFF, 32'h40000000, 2'b00, 32'h7F800000, 4'b0101, 1'b1);
    send(32'h7F7FFFFF, 32'h40000000, 2'b01, 32'h7F7FFFFF, 4'b0101, 1'b1);
    send(32'h7F7FFFFF, 32'h40000000, 2'b10, 32'h7F800000, 4'b0101, 1'b1);
    send(32'h7F7FFFFF, 32'h40000000, 2'b11, 32'h7F7FFFFF, 4'b0101, 1'b1);
    send(32'hFF7FFFFF, 32'h40000000, 2'b10, 32'hFF7FFFFF, 4'b0101, 1'b1);
    send(32'hFF7FFFFF, 32'h40000000, 2'b11, 32'hFF800000, 4'b0101, 1'b1);
    send(32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, 4'b1000, 1'b1);
    send(32'h00000000, 32'hFF800000, 2'b00, 32'h7FC00000, 4'b1000, 1'b1);
    send(32'h00400000, 32'h40000000, 2'b00, 32'h00800000, 4'b0000, 1'b1);
    send(32'h00800000, 32'h3F000000, 2'b00, 32'h00000000, 4'b0011, 1'b1);
    send(32'h80800000, 32'h3F000000, 2'b00, 32'h80000000, 4'b0011, 1'b1);
    // ties: odd lsb rounds up, even lsb stays
    send(32'h3FC00000, 32'h3F800001, 2'b00, 32'h3FC00002, 4'b0001, 1'b1);
    send(32'h3F800002, 32'h3FA00000, 2'b00, 32'h3FA00002, 4'b0001, 1'b1);
    send(32'h3F800002, 32'h3FA00000, 2'b10, 32'h3FA00003, 4'b0001, 1'b1);
    // mantissa product is 2^47-1: rounding carries into the exponent
    send(32'h3FCA6691, 32'h3FA1E58F, 2'b00, 32'h40000000, 4'b0001, 1'b1);
    send(32'h3FCA6691, 32'h3FA1E58F, 2'b01, 32'h3FFFFFFF, 4'b0001, 1'b1);
    send(32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b1000, 1'b1);
    send(32'h7FC00001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b0000, 1'b1);
    send(32'h7F800000, 32'hC0000000, 2'b00, 32'hFF800000, 4'b0000, 1'b1);
    send(32'h80000000, 32'h40400000, 2'b00, 32'h80000000, 4'b0000, 1'b1);

    // back-pressure: result must hold while out_ready is low
    wait_idle();
    out_ready = 1'b0;
    send(32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 4'b0001, 1'b1);
    g = 0;
    while (!out_valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("stall_valid_seen", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_out_c%0d", i), out, 32'h3F800003);
      check($sformatf("stall_flags_c%0d", i), {28'b0, flags}, 32'h1);
      check($sformatf("stall_valid_c%0d", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("stall_in_ready_c%0d", i), {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;

    // reset in the middle of MUL discards the operation
    wait_idle();
    send(32'h3FC00000, 32'h40000000, 2'b00, 32'h0, 4'b0000, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("midrst_state_mul", {29'b0, dbg_state}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out", out, 32'h0);
    check("midrst_flags", {28'b0, flags}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000, 1'b1);

    // drain
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_pending", exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("final_in_ready", {31'b0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpmul_stream.md
FPMUL_STREAM -- requirements
Module: fpmul_stream

Interface
REQ-001 SHALL have parameter LOG_BIT, default 5, meaning log2 of word width.
REQ-002 SHALL have parameter EXP_BIT, default 8, meaning exponent field width.
REQ-003 SHALL have parameter N_BIT, default 1<<LOG_BIT, meaning word width.
REQ-004 SHALL have parameter MAN_BIT, default N_BIT-EXP_BIT-1, meaning stored mantissa width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: operands and rm are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept.
REQ-009 SHALL have port a, input, N_BIT bits: operand A, IEEE-754 layout.
REQ-010 SHALL have port b, input, N_BIT bits: operand B.
REQ-011 SHALL have port rm, input, 2 bits: rounding mode, 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf).
REQ-012 SHALL have port out_valid, output, 1 bit: result valid.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-014 SHALL have port out, output, N_BIT bits: product.
REQ-015 SHALL have port flags, output, 4 bits: [3] NV invalid, [2] OF overflow, [1] UF underflow, [0] NX inexact.

Function
REQ-016 SHALL implement FSM IDLE -> MUL -> NORM -> ROUND -> DONE -> IDLE.
REQ-017 SHALL drive in_ready=1 only in IDLE; accept on in_valid&&in_ready, registering a, b, rm; IDLE->MUL.
REQ-018 SHALL multiply {hidden,man} operands in MUL by radix-2 shift-add over exactly MAN_BIT+1 cycles (cycle counter), into a 2*MAN_BIT+2-bit product.
REQ-019 SHALL use hidden bit 1 for normal inputs and 0 with effective exponent 1 for denormal inputs.
REQ-020 SHALL compute exponent ea+eb-bias, bias=2^(EXP_BIT-1)-1, signed, width EXP_BIT+2, no wrap-around.
REQ-021 SHALL in NORM (1 cycle) shift product right 1 with exp+1 if MSB set, else left-normalise by leading-zero count with exp decremented by that count.
REQ-022 SHALL in ROUND (1 cycle) round by guard bit plus sticky (OR of lower bits) per rm; RNE ties-to-even; mantissa carry-out renormalises with exp+1.
REQ-023 SHALL on rounded biased exp >= 2^EXP_BIT-1 set OF|NX; result inf for RNE, max-finite for RTZ, +inf/-max-finite for RUP, -inf/+max-finite for RDN, depending on sign.
REQ-024 SHALL on rounded biased exp <= 0 flush to signed zero with UF|NX; no denormal outputs.
REQ-025 SHALL set NX whenever guard or sticky is nonzero.
REQ-026 SHALL output canonical qNaN (sign 0, exp all ones, man MSB 1, rest 0) for any NaN input or inf*0.
REQ-027 SHALL set NV for inf*0 or any signalling NaN input (man MSB 0, man nonzero).
REQ-028 SHALL output inf with sign a^b for inf*nonzero; signed zero for zero*finite; no flags.
REQ-029 SHALL use the same latency for special cases: out_valid rises on the (MAN_BIT+4)th rising edge after the accept edge, 27 for defaults.
REQ-030 SHALL in DONE hold out_valid=1 and out, flags stable until out_ready=1; on that edge go to IDLE, clear out_valid.
REQ-031 SHALL accept no new input while out_valid=1, so accept and output transfer never overlap.

Reset
REQ-032 SHALL on rst force IDLE, in_ready=1, out_valid=0, out=0, flags=0, counter=0, asynchronously, in any state.
REQ-033 SHALL discard any in-flight operation on rst mid-operation; no result is produced for it.

Verification
REQ-034 SHALL verify 0x3FC00000*0x40000000, RNE -> out=0x40400000, flags=0, out_valid on the 27th edge after accept.
REQ-035 SHALL verify 0x3F800001*0x3F800001 -> RNE 0x3F800002, RTZ 0x3F800002, RUP 0x3F800003, all NX.
REQ-036 SHALL verify 0x7F7FFFFF*0x40000000 -> RNE 0x7F800000 flags OF|NX; RTZ 0x7F7FFFFF flags OF|NX.
REQ-037 SHALL verify 0x7F800000*0x00000000 -> 0x7FC00000 NV; 0x00400000*0x40000000 -> 0x00800000 flags 0; 0x00800000*0x3F000000 -> 0x00000000 UF|NX.
REQ-038 SHALL verify out_ready held low 5 cycles -> out, flags, out_valid stable and in_ready=0.
REQ-039 SHALL verify rst pulsed during MUL -> out_valid=0, in_ready=1 immediately; the next operation completes correctly.
